bitblaster_core_p: RTL
======================

# bitblaster_core_p

Parametrised multi-cycle processor core: the next generation of the 10-bit Bitblaster datapath, generalised in data width and register count. It integrates the instruction register, timestep counter, controller FSM, register file and multi-stage ALU (A/G registers) behind a valid/ready instruction handshake. It adds status flags, illegal-opcode detection and a debug read port. It sits below the board-level wrapper, which supplies debounced clock, switch data and display logic.

## Interface

- DATA_W, 10, data bus, register and instruction width; must satisfy DATA_W >= 6 + 2*RA_W.
- RA_W, 2, register address width; NUM_REGS = 2**RA_W.
- CLKb  in  1  sole clock; all state updates on its rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- instr_in  in  DATA_W  instruction word.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  core can accept; high only in T0.
- data_in  in  DATA_W  external data for ld; sampled at the end of T1.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  DATA_W  combinational read of R[dbg_addr].
- bus_out  out  DATA_W  current internal data-bus value (0 when undriven).
- timestep  out  2  current timestep T0..T3.
- done  out  1  high during the final timestep of a legal instruction.
- illegal  out  1  one-cycle pulse in T1 for an undefined opcode.
- flag_z, flag_n, flag_c  out  1 each  status flags.

## Operation

- Instruction fields: class = instr[DATA_W-1:DATA_W-2]; Rx = next RA_W bits; Ry = the RA_W bits above fn; fn = instr[3:0]; imm = instr[DATA_W-3-RA_W:0], zero-extended.
- Class 00 fn codes: 0 ld, 1 cp, 2 add, 3 sub, 4 inv (two's complement of Ry), 5 flp, 6 and, 7 or, 8 xor, 9 lsl, A lsr, B asr. Class 10 is addi; class 11 is subi.
- Illegal: class 01, or class 00 with fn C..F. These pulse `illegal` in T1, cause no register or flag change, and return to T0.
- T0: instr_ready=1. When instr_valid && instr_ready, the IR loads instr_in and the FSM goes to T1.
- ld: in T1, Rx <= data_in; done.
- cp: in T1, Rx <= R[Ry]; done.
- inv/flp (one operand, no A step): in T1, G <= fn(R[Ry]). In T2, Rx <= G; done.
- Two-operand and immediate ops: in T1, A <= R[Rx]. In T2, G <= A fn (R[Ry] or imm). In T3, Rx <= G; done.
- Shifts use the full value of R[Ry] as the amount. An amount >= DATA_W gives 0 for lsl/lsr and DATA_W copies of the sign bit for asr.
- Arithmetic is modulo 2**DATA_W.
- Flags update only when G loads:
  - Z = (G==0); N = G[DATA_W-1].
  - C = carry-out for add/addi, no-borrow (A >= operand) for sub/subi, 0 for all other ops.
- After the done timestep, the FSM returns to T0. Rx==Ry is legal and reads old values.

## Timing

- Reset (asynchronous, immediate):
  - Registers: all R, IR, A, G = 0.
  - Flags: 0.
  - timestep = 0, so instr_ready = 1 and done = illegal = 0.
- Reset mid-instruction aborts it: no write occurs, and the core restarts in T0 after RSTn rises.
- Latency from the accepting edge to the write edge:
  - 1 cycle for ld/cp.
  - 2 cycles for inv/flp.
  - 3 cycles for ALU/immediate ops.
- The next instruction can be accepted in the cycle after done.
- The register write and `done` coincide: done is high for the cycle whose ending edge commits Rx.
- instr_valid outside T0 is ignored; instr_in must be held only until accepted.
- dbg_data reflects a write on the cycle after the committing edge.
- The timestep counter never exceeds T3 and wraps to T0.

## Test plan

- Reset, then ld R1 (instr 0x040, data_in 0x155) -> done in T1 one cycle after accept; dbg_data for R1 = 0x155; other registers 0.
- R0=0x3FF, R1=0x001, then add R0,R1 (0x012) -> done in T3; R0=0x000; Z=1, C=1, N=0.
- R2=0x003, then subi R2,5 (0x385) -> R2=0x3FE; N=1, C=0, Z=0.
- R3=0x200, R0=3, then asr R3,R0 (0x0CB) -> R3=0x3C0. Repeat with R3=0x200, R0=12 -> R3=0x3FF. Also lsl with R0=12 -> 0.
- R1=0x005, then inv R2,R1 (0x094) -> done in T2 (not T3); R2=0x3FB; N=1.
- Apply 0x100 (class 01) -> illegal pulses in T1, no state change, instr_ready back high next cycle. Then add with RSTn pulsed low in T2 -> all registers 0 and timestep 0 immediately; no write.

Source files
------------

// File: rtl/bitblaster_core_p.sv
// Parametrised Bitblaster multi-cycle core: IR, T0..T3 controller, register file,
// A/G ALU staging, status flags, illegal-opcode detect and debug read port.
module bitblaster_core_p #(
  parameter int DATA_W = 10,
  parameter int RA_W   = 2
) (
  input  logic              CLKb,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] bus_out,
  output logic [1:0]        timestep,
  output logic              done,
  output logic              illegal,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  localparam int NUM_REGS = 2**RA_W;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  tstep_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, a_q, g_q, g_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              z_q, n_q, c_q, c_d;

  logic [1:0]        cls;
  logic [RA_W-1:0]   rx, ry;
  logic [3:0]        fn;
  logic [DATA_W-1:0] imm, rd_x, rd_y, opb;
  logic [DATA_W:0]   sum, diff;
  logic              is_ill, is_mov, is_unary;
  logic              we, load_a, load_g, accept;
  logic [DATA_W-1:0] wdata;

  assign cls  = ir_q[DATA_W-1 -: 2];
  assign rx   = ir_q[DATA_W-3 -: RA_W];
  assign ry   = ir_q[4 +: RA_W];
  assign fn   = ir_q[3:0];
  assign imm  = DATA_W'(ir_q[DATA_W-3-RA_W:0]);
  assign rd_x = regs_q[rx];
  assign rd_y = regs_q[ry];
  assign opb  = cls[1] ? imm : rd_y;
  assign sum  = {1'b0, a_q} + {1'b0, opb};
  assign diff = {1'b0, a_q} - {1'b0, opb};

  assign is_ill   = (cls == 2'b01) || (cls == 2'b00 && fn >= 4'hC);
  assign is_mov   = (cls == 2'b00) && (fn == 4'h0 || fn == 4'h1);
  assign is_unary = (cls == 2'b00) && (fn == 4'h4 || fn == 4'h5);

  // Unary ops read Ry directly in T1; all others operate on A in T2.
  always_comb begin
    g_d = '0;
    c_d = 1'b0;
    if (cls[1]) begin
      if (cls[0]) begin
        g_d = diff[DATA_W-1:0];
        c_d = (a_q >= opb);
      end else begin
        g_d = sum[DATA_W-1:0];
        c_d = sum[DATA_W];
      end
    end else begin
      case (fn)
        4'h2: begin g_d = sum[DATA_W-1:0];  c_d = sum[DATA_W]; end
        4'h3: begin g_d = diff[DATA_W-1:0]; c_d = (a_q >= opb); end
        4'h4: g_d = '0 - rd_y;
        4'h5: g_d = ~rd_y;
        4'h6: g_d = a_q & opb;
        4'h7: g_d = a_q | opb;
        4'h8: g_d = a_q ^ opb;
        4'h9: g_d = a_q << opb;
        4'hA: g_d = a_q >> opb;
        4'hB: g_d = DATA_W'($signed(a_q) >>> opb);
        default: g_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    bus_out     = '0;
    we          = 1'b0;
    wdata       = '0;
    load_a      = 1'b0;
    load_g      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      T0: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        state_d = T2;
        if (is_ill) begin
          illegal = 1'b1;
          state_d = T0;
        end else if (is_mov) begin
          wdata   = (fn == 4'h0) ? data_in : rd_y;
          bus_out = wdata;
          we      = 1'b1;
          done    = 1'b1;
          state_d = T0;
        end else if (is_unary) begin
          bus_out = rd_y;
          load_g  = 1'b1;
        end else begin
          bus_out = rd_x;
          load_a  = 1'b1;
        end
      end
      T2: begin
        if (is_unary) begin
          wdata   = g_q;
          bus_out = g_q;
          we      = 1'b1;
          done    = 1'b1;
          state_d = T0;
        end else begin
          bus_out = opb;
          load_g  = 1'b1;
          state_d = T3;
        end
      end
      default: begin
        wdata   = g_q;
        bus_out = g_q;
        we      = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
    endcase
  end

  always_ff @(posedge CLKb or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLKb or negedge RSTn) begin
    if (!RSTn) begin
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      c_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (accept) ir_q <= instr_in;
      if (load_a) a_q <= rd_x;
      if (load_g) begin
        g_q <= g_d;
        z_q <= (g_d == '0);
        n_q <= g_d[DATA_W-1];
        c_q <= c_d;
      end
      if (we) regs_q[rx] <= wdata;
    end
  end

  assign dbg_data = regs_q[dbg_addr];
  assign timestep = state_q;
  assign flag_z   = z_q;
  assign flag_n   = n_q;
  assign flag_c   = c_q;

endmodule
